// File: rtl/extensor_imediato.sv
// Pipelined immediate extender (sign / zero / upper / branch) with a two-entry skid buffer.
// Define EXTENSOR_BRANCH_SHIFT_EN to make mode 11 shift the sign-extended value left by 2.
module extensor_imediato #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int PAD_W = OUT_W - IN_W;

  // Occupancy of the main (M) and skid (S) registers; S is only ever full when M is.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] mData_q, mData_d;
  logic [OUT_W-1:0] sData_q, sData_d;
  logic [1:0]       mMode_q, mMode_d;
  logic [1:0]       sMode_q, sMode_d;

  logic [OUT_W-1:0] sextVal;
  logic [OUT_W-1:0] extVal;
  logic             inFire;
  logic             outFire;

  // The word is extended once at acceptance so both registers hold final results.
  always_comb begin
    sextVal = {{PAD_W{in_data[IN_W-1]}}, in_data};
    extVal  = sextVal;
    case (in_mode)
      2'b00:   extVal = sextVal;
      2'b01:   extVal = {{PAD_W{1'b0}}, in_data};
      2'b10:   extVal = {in_data, {PAD_W{1'b0}}};
      2'b11: begin
`ifdef EXTENSOR_BRANCH_SHIFT_EN
        extVal = {sextVal[OUT_W-3:0], 2'b00};
`else
        extVal = sextVal;
`endif
      end
      default: extVal = sextVal;
    endcase
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = mData_q;
  assign out_mode  = mMode_q;

  assign inFire  = in_valid && in_ready;
  assign outFire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    mData_d = mData_q;
    mMode_d = mMode_q;
    sData_d = sData_q;
    sMode_d = sMode_q;
    case (state_q)
      EMPTY: begin
        if (inFire) begin
          mData_d = extVal;
          mMode_d = in_mode;
          state_d = ONE;
        end
      end
      ONE: begin
        if (inFire && outFire) begin
          mData_d = extVal;
          mMode_d = in_mode;
        end else if (inFire) begin
          // Consumer stalled: park the new word behind the one on the outputs.
          sData_d = extVal;
          sMode_d = in_mode;
          state_d = FULL;
        end else if (outFire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (outFire) begin
          mData_d = sData_q;
          mMode_d = sMode_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      mData_q <= '0;
      mMode_q <= 2'b00;
      sData_q <= '0;
      sMode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      mData_q <= mData_d;
      mMode_q <= mMode_d;
      sData_q <= sData_d;
      sMode_q <= sMode_d;
    end
  end

endmodule

// File: tb/tb_extensor_imediato.sv
// Self-checking bench for extensor_imediato: directed vector table, backpressure,
// random-stall streaming against a scoreboard, reset in FULL, and an 8->16 instance.
module tb_extensor_imediato;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  logic        nInValid;
  logic        nInReady;
  logic [7:0]  nInData;
  logic [1:0]  nInMode;
  logic        nOutValid;
  logic        nOutReady;
  logic [15:0] nOutData;
  logic [1:0]  nOutMode;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  extensor_imediato #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  extensor_imediato #(.IN_W(8), .OUT_W(16)) dutNarrow (
    .clk(clk), .rst_n(rst_n),
    .in_valid(nInValid), .in_ready(nInReady), .in_data(nInData), .in_mode(nInMode),
    .out_valid(nOutValid), .out_ready(nOutReady), .out_data(nOutData), .out_mode(nOutMode)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [31:0] expData;
  } vec_t;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  data;
    logic [15:0] expData;
  } nvec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    nAssert++;
    if (actual !== required) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
  endtask

  // Reference extension for the 16->32 instance, written from the mode descriptions.
  function automatic logic [31:0] refExt(input logic [15:0] d, input logic [1:0] m);
    logic signed [31:0] s;
    s = 32'(signed'(d));
    case (m)
      2'b00:   refExt = s;
      2'b01:   refExt = {16'h0000, d};
      2'b10:   refExt = {d, 16'h0000};
`ifdef EXTENSOR_BRANCH_SHIFT_EN
      default: refExt = s * 4;
`else
      default: refExt = s;
`endif
    endcase
  endfunction

  initial begin
    vec_t        vecs[9];
    nvec_t       nvecs[4];
    logic [33:0] sb[$];
    logic [33:0] expWord;
    logic [31:0] lastData;
    bit          lastStall;
    bit          pend;
    int          sent;
    int          recv;
    int          cyc;

    vecs[0] = '{2'b00, 16'h8000, 32'hFFFF8000};
    vecs[1] = '{2'b00, 16'h7FFF, 32'h00007FFF};
    vecs[2] = '{2'b01, 16'h8000, 32'h00008000};
    vecs[3] = '{2'b10, 16'h1234, 32'h12340000};
    vecs[6] = '{2'b10, 16'hFFFF, 32'hFFFF0000};
    vecs[7] = '{2'b01, 16'hFFFF, 32'h0000FFFF};
`ifdef EXTENSOR_BRANCH_SHIFT_EN
    vecs[4] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
    vecs[5] = '{2'b11, 16'h4001, 32'h00010004};
    vecs[8] = '{2'b11, 16'h8000, 32'hFFFE0000};
`else
    vecs[4] = '{2'b11, 16'hFFFF, 32'hFFFFFFFF};
    vecs[5] = '{2'b11, 16'h4001, 32'h00004001};
    vecs[8] = '{2'b11, 16'h8000, 32'hFFFF8000};
`endif

    nvecs[0] = '{2'b00, 8'h80, 16'hFF80};
    nvecs[1] = '{2'b10, 8'hAB, 16'hAB00};
    nvecs[2] = '{2'b01, 8'h80, 16'h0080};
`ifdef EXTENSOR_BRANCH_SHIFT_EN
    nvecs[3] = '{2'b11, 8'h81, 16'hFE04};
`else
    nvecs[3] = '{2'b11, 8'h81, 16'hFF81};
`endif

    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0000, 2'b00);
    nInValid  = 1'b0;
    nInData   = 8'h00;
    nInMode   = 2'b00;
    nOutReady = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_data", out_data, 32'h0);
    checkOutput("reset_out_mode", 32'(out_mode), 32'd0);
    rst_n = 1'b1;

    // Back-to-back table vectors, each checked one edge after acceptance.
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      applyStimulus(1'b1, vecs[i].data, vecs[i].mode);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d_mode", i), 32'(out_mode), 32'(vecs[i].mode));
    end
    applyStimulus(1'b0, 16'h0000, 2'b00);
    @(negedge clk);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: two words fit, the third waits, order preserved on release.
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h0001, 2'b01);
    @(negedge clk);
    checkOutput("bp_first_data", out_data, 32'h1);
    checkOutput("bp_in_ready_one", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 16'h0002, 2'b01);
    @(negedge clk);
    checkOutput("bp_in_ready_full", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_data", out_data, 32'h1);
    applyStimulus(1'b1, 16'h0003, 2'b01);
    @(negedge clk);
    checkOutput("bp_still_full", 32'(in_ready), 32'd0);
    checkOutput("bp_still_hold", out_data, 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_second_data", out_data, 32'h2);
    checkOutput("bp_ready_again", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("bp_third_data", out_data, 32'h3);
    checkOutput("bp_third_mode", 32'(out_mode), 32'd1);
    applyStimulus(1'b0, 16'h0000, 2'b00);
    @(negedge clk);
    checkOutput("bp_empty", 32'(out_valid), 32'd0);

    // Random stalls on both sides against an in-order scoreboard.
    sent = 0;
    recv = 0;
    cyc = 0;
    pend = 0;
    lastStall = 0;
    lastData = '0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!pend) in_valid = 1'b0;
      if (!pend && sent < 1000 && $urandom_range(3) != 0) begin
        applyStimulus(1'b1, 16'($urandom), 2'($urandom));
        pend = 1;
      end
      out_ready = 1'($urandom_range(1));
      #1;
      if (lastStall) checkOutput("stream_hold", out_data, lastData);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("stream_spurious", 32'(sb.size()), 32'd1);
        end else begin
          expWord = sb.pop_front();
          checkOutput($sformatf("stream%0d_data", recv), out_data, expWord[31:0]);
          checkOutput($sformatf("stream%0d_mode", recv), 32'(out_mode), 32'(expWord[33:32]));
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_mode, refExt(in_data, in_mode)});
        sent++;
        pend = 0;
      end
      lastStall = out_valid && !out_ready;
      lastData  = out_data;
    end
    checkOutput("stream_count", 32'(recv), 32'd1000);
    applyStimulus(1'b0, 16'h0000, 2'b00);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Fill to FULL, then reset while transfers are being offered.
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'hAAAA, 2'b00);
    @(negedge clk);
    applyStimulus(1'b1, 16'hBBBB, 2'b00);
    @(negedge clk);
    checkOutput("rst_full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b1, 16'h1111, 2'b10);
    @(negedge clk);
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_out_data", out_data, 32'h0);
    checkOutput("rst_mid_out_mode", 32'(out_mode), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h00FF, 2'b00);
    @(negedge clk);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_data", out_data, 32'h000000FF);
    applyStimulus(1'b0, 16'h0000, 2'b00);
    @(negedge clk);
    checkOutput("post_rst_empty", 32'(out_valid), 32'd0);

    // Narrow 8->16 instance.
    for (int i = 0; i < 4; i++) begin
      nInValid = 1'b1;
      nInData  = nvecs[i].data;
      nInMode  = nvecs[i].mode;
      @(negedge clk);
      checkOutput($sformatf("narrow%0d_valid", i), 32'(nOutValid), 32'd1);
      checkOutput($sformatf("narrow%0d_data", i), 32'(nOutData), 32'(nvecs[i].expData));
      checkOutput($sformatf("narrow%0d_mode", i), 32'(nOutMode), 32'(nvecs[i].mode));
    end
    nInValid = 1'b0;
    @(negedge clk);
    checkOutput("narrow_ready", 32'(nInReady), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
